// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x4 active-low keypad scanner with per-key debounce and one-cycle key strobe.
// Define KEY_REPEAT_EN to add auto-repeat strobes while a key stays held.
module key_matrix_scan #(
   parameter int SCAN_DIV = 1000,
   parameter int DEB_CNT  = 4
`ifdef KEY_REPEAT_EN
   ,parameter int REPEAT_DLY = 200
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_row,
   output logic [3:0] key_col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEB_CNT + 1);
   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
   state_t        state_q, state_d;
   logic [3:0]    sync1_q, row_s_q, key_col_q, key_code_q;
   logic [CW-1:0] div_q;
   logic [1:0]    col_q, col_d, row_q, row_d, row_idx;
   logic [DW-1:0] deb_q, deb_d, rel_q, rel_d;
   logic          key_valid_q, key_held_q, held_d, accept, rep_hit;
   logic          sample, any_low, latched_low;
   assign sample      = div_q == CW'(SCAN_DIV - 1);
   assign any_low     = ~&row_s_q;
   assign latched_low = ~row_s_q[row_q];
   assign row_idx     = !row_s_q[0] ? 2'd0 : !row_s_q[1] ? 2'd1 : !row_s_q[2] ? 2'd2 : 2'd3;
   assign key_col     = key_col_q;
   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_held    = key_held_q;
`ifdef KEY_REPEAT_EN
   localparam int RW = $clog2(REPEAT_DLY + 1);
   logic [RW-1:0] rep_q;
   logic          rep_step;
   assign rep_step = state_q == PRESSED && sample && latched_low;
   assign rep_hit  = rep_step && rep_q == RW'(REPEAT_DLY - 1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rep_q <= '0;
      else rep_q <= (accept || rep_hit) ? '0 : rep_step ? rep_q + 1'b1 : rep_q;
   end
`else
   assign rep_hit = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      deb_d   = deb_q;
      rel_d   = rel_q;
      held_d  = key_held_q;
      accept  = 1'b0;
      if (sample) begin
         case (state_q)
            SCAN: if (any_low) begin
               row_d   = row_idx;
               deb_d   = DW'(1);
               state_d = DEBOUNCE;
               accept  = DEB_CNT == 1;
            end else col_d = col_q + 2'd1;
            DEBOUNCE: if (any_low && row_idx == row_q) begin
               deb_d  = deb_q + 1'b1;
               accept = deb_d == DW'(DEB_CNT);
            end else begin
               state_d = SCAN;
               col_d   = col_q + 2'd1;
               deb_d   = '0;
            end
            PRESSED: if (latched_low) rel_d = '0;
            else if (rel_q + 1'b1 == DW'(DEB_CNT)) begin
               rel_d   = '0;
               held_d  = 1'b0;
               state_d = SCAN;
               col_d   = col_q + 2'd1;
            end else rel_d = rel_q + 1'b1;
            default: state_d = SCAN;
         endcase
      end
      if (accept) begin
         state_d = PRESSED;
         deb_d   = '0;
         rel_d   = '0;
         held_d  = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q     <= 4'hF;
         row_s_q     <= 4'hF;
         state_q     <= SCAN;
         div_q       <= '0;
         col_q       <= '0;
         row_q       <= '0;
         deb_q       <= '0;
         rel_q       <= '0;
         key_col_q   <= 4'b1110;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         sync1_q     <= key_row;
         row_s_q     <= sync1_q;
         state_q     <= state_d;
         div_q       <= sample ? '0 : div_q + 1'b1;
         col_q       <= col_d;
         row_q       <= row_d;
         deb_q       <= deb_d;
         rel_q       <= rel_d;
         key_col_q   <= ~(4'b0001 << col_d);
         key_code_q  <= accept ? {row_d, col_q} : key_code_q;
         key_valid_q <= accept | rep_hit;
         key_held_q  <= held_d;
      end
   end
endmodule
